// File: rtl/slc3_mem_responder.sv
// rtl/slc3_mem_responder.sv - SLC-3 memory responder with wait states and optional I/O word
//
// Answers active-low strobe requests from the SLC-3 control unit out of an
// on-chip 2^ADDR_W x 16 word array.
//   Clk, Reset           clock and synchronous active-low reset
//   Mem_CE/OE/WE/UB/LB   active-low chip enable, read, write, byte lanes
//   ADDR, Data_in        word address (MAR) and write data (MDR)
//   Switches             board switch word, read back at 0xFFFF
//   Data_out, mem_ready  registered read data and request-complete flag
//   Hex_out              registered I/O display word
// Optional feature macro: SLC3_MEM_IO_EN (maps 0xFFFF to Switches/Hex_out).
module slc3_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_in,
    input  logic [15:0] Switches,
    output logic [15:0] Data_out,
    output logic        mem_ready,
    output logic [15:0] Hex_out
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] RD_HOLD = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] WR_HOLD = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ub_q, ub_d;
    logic        lb_q, lb_d;
    logic [15:0] dout_q, dout_d;
    logic        ready_q, ready_d;

    logic [15:0] mem [DEPTH];

    // Response operands: the live inputs when responding on the recognition
    // edge (WAIT_CYCLES = 0), otherwise the values captured at recognition.
    logic        do_read, do_write;
    logic [15:0] rsp_addr, rsp_wdata;
    logic        rsp_ub, rsp_lb;
    logic        rsp_in_range, rsp_io;
    logic [ADDR_W-1:0] mem_idx;
    logic        mem_wr;

    assign rsp_in_range = ((rsp_addr >> ADDR_W) == 16'd0);
    assign mem_idx      = rsp_addr[ADDR_W-1:0];

`ifdef SLC3_MEM_IO_EN
    logic [15:0] hex_q, hex_d;
    assign rsp_io  = (rsp_addr == 16'hFFFF);
    assign Hex_out = hex_q;
`else
    logic unused_switches;
    assign rsp_io          = 1'b0;
    assign Hex_out         = 16'h0000;
    assign unused_switches = ^Switches;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ub_d      = ub_q;
        lb_d      = lb_q;
        dout_d    = dout_q;
        ready_d   = ready_q;
        do_read   = 1'b0;
        do_write  = 1'b0;
        rsp_addr  = addr_q;
        rsp_wdata = wdata_q;
        rsp_ub    = ub_q;
        rsp_lb    = lb_q;
        case (state_q)
            IDLE: begin
                if (!Mem_CE && (!Mem_WE || !Mem_OE)) begin
                    addr_d    = ADDR;
                    wdata_d   = Data_in;
                    ub_d      = Mem_UB;
                    lb_d      = Mem_LB;
                    cnt_d     = WAIT_INIT;
                    rsp_addr  = ADDR;
                    rsp_wdata = Data_in;
                    rsp_ub    = Mem_UB;
                    rsp_lb    = Mem_LB;
                    // Write has priority when both strobes are low.
                    if (!Mem_WE) begin
                        if (WAIT_INIT == 4'd0) begin
                            do_write = 1'b1;
                            state_d  = WR_HOLD;
                        end else begin
                            state_d  = WR_WAIT;
                        end
                    end else begin
                        if (WAIT_INIT == 4'd0) begin
                            do_read = 1'b1;
                            state_d = RD_HOLD;
                        end else begin
                            state_d = RD_WAIT;
                        end
                    end
                end
            end
            // cnt_q counts the edges still to go; the response lands on the
            // edge where it would reach zero.
            RD_WAIT: begin
                if (Mem_CE || Mem_OE) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        do_read = 1'b1;
                        state_d = RD_HOLD;
                    end
                end
            end
            RD_HOLD: begin
                if (Mem_CE || Mem_OE) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                if (Mem_CE || Mem_WE) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        do_write = 1'b1;
                        state_d  = WR_HOLD;
                    end
                end
            end
            WR_HOLD: begin
                if (Mem_CE || Mem_WE) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_read) begin
            ready_d = 1'b1;
            if (rsp_io) begin
                dout_d = Switches;
            end else if (rsp_in_range) begin
                dout_d = mem[mem_idx];
            end else begin
                dout_d = 16'h0000;
            end
        end
        if (do_write) begin
            ready_d = 1'b1;
        end
    end

    // A commit coinciding with reset is dropped.
    assign mem_wr = do_write && Reset && rsp_in_range && !rsp_io;

`ifdef SLC3_MEM_IO_EN
    always_comb begin
        hex_d = hex_q;
        if (do_write && rsp_io) begin
            if (!rsp_ub) hex_d[15:8] = rsp_wdata[15:8];
            if (!rsp_lb) hex_d[7:0]  = rsp_wdata[7:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) hex_q <= 16'h0000;
        else        hex_q <= hex_d;
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            dout_q  <= 16'h0000;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ub_q    <= ub_d;
            lb_q    <= lb_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
        end
    end

    // Array is not reset so its contents survive Reset.
    always_ff @(posedge Clk) begin
        if (mem_wr) begin
            if (!rsp_ub) mem[mem_idx][15:8] <= rsp_wdata[15:8];
            if (!rsp_lb) mem[mem_idx][7:0]  <= rsp_wdata[7:0];
        end
    end

    assign Data_out  = dout_q;
    assign mem_ready = ready_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// tb/tb_slc3_mem_responder.sv - directed self-checking bench for slc3_mem_responder
module tb_slc3_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Mem_CE = 1'b1, Mem_OE = 1'b1, Mem_WE = 1'b1;
    logic        Mem_UB = 1'b0, Mem_LB = 1'b0;
    logic [15:0] ADDR = 16'h0000, Data_in = 16'h0000, Switches = 16'h0000;

    logic [15:0] dout0, hex0, dout3, hex3, dout2, hex2;
    logic        rdy0, rdy3, rdy2;

    int total = 0;
    int passed = 0;

`ifdef SLC3_MEM_IO_EN
    localparam logic [15:0] EXP_IO_RD  = 16'h3000;
    localparam logic [15:0] EXP_HEX_1  = 16'h00C5;
    localparam logic [15:0] EXP_HEX_2  = 16'h0011;
`else
    localparam logic [15:0] EXP_IO_RD  = 16'h0000;
    localparam logic [15:0] EXP_HEX_1  = 16'h0000;
    localparam logic [15:0] EXP_HEX_2  = 16'h0000;
`endif

    slc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_in(Data_in),
        .Switches(Switches), .Data_out(dout0), .mem_ready(rdy0), .Hex_out(hex0));

    slc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut_w3 (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_in(Data_in),
        .Switches(Switches), .Data_out(dout3), .mem_ready(rdy3), .Hex_out(hex3));

    slc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_in(Data_in),
        .Switches(Switches), .Data_out(dout2), .mem_ready(rdy2), .Hex_out(hex2));

    always #5 Clk = ~Clk;

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic release_bus;
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    endtask

    // Two-cycle WE-low write as issued by the CPU, then one idle cycle.
    task automatic write0(input logic [15:0] a, input logic [15:0] d, input logic ub, input logic lb);
        Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = a; Data_in = d; Mem_UB = ub; Mem_LB = lb;
        step; step;
        release_bus; Mem_UB = 1'b0; Mem_LB = 1'b0;
        step; step;
    endtask

    task automatic read0_start(input logic [15:0] a);
        Mem_CE = 1'b0; Mem_OE = 1'b0; ADDR = a;
        step;
    endtask

    task automatic read0_end;
        release_bus;
        step; step;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        step; step;
        total++; if (rdy0 !== 1'b0) $display("FAIL reset_ready: got %b expected 0", rdy0); else passed++;
        total++; if (dout0 !== 16'h0000) $display("FAIL reset_dout: got %h expected 0000", dout0); else passed++;
        total++; if (hex0 !== 16'h0000) $display("FAIL reset_hex: got %h expected 0000", hex0); else passed++;
        total++; if (rdy3 !== 1'b0) $display("FAIL reset_ready_w3: got %b expected 0", rdy3); else passed++;
        Reset = 1'b1;
        step;
    endtask

    task automatic test_write_read;
        Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 16'h0005; Data_in = 16'h1234;
        step;
        total++; if (rdy0 !== 1'b1) $display("FAIL wr_ready_rise: got %b expected 1", rdy0); else passed++;
        step;
        release_bus;
        step;
        total++; if (rdy0 !== 1'b0) $display("FAIL wr_ready_clear: got %b expected 0", rdy0); else passed++;
        step;
        read0_start(16'h0005);
        total++; if (dout0 !== 16'h1234) $display("FAIL rd_data: got %h expected 1234", dout0); else passed++;
        total++; if (rdy0 !== 1'b1) $display("FAIL rd_ready: got %b expected 1", rdy0); else passed++;
        release_bus;
        step;
        total++; if (rdy0 !== 1'b0) $display("FAIL rd_ready_clear: got %b expected 0", rdy0); else passed++;
        total++; if (dout0 !== 16'h1234) $display("FAIL rd_data_hold: got %h expected 1234", dout0); else passed++;
        step;
    endtask

    task automatic test_byte_lanes;
        write0(16'h0003, 16'hFFFF, 1'b0, 1'b0);
        write0(16'h0003, 16'hAB00, 1'b0, 1'b1);
        read0_start(16'h0003);
        total++; if (dout0 !== 16'hABFF) $display("FAIL lane_upper: got %h expected abff", dout0); else passed++;
        read0_end;
        write0(16'h0003, 16'h0000, 1'b1, 1'b1);
        read0_start(16'h0003);
        total++; if (dout0 !== 16'hABFF) $display("FAIL lane_none: got %h expected abff", dout0); else passed++;
        read0_end;
        write0(16'h0003, 16'h5512, 1'b1, 1'b0);
        read0_start(16'h0003);
        total++; if (dout0 !== 16'hAB12) $display("FAIL lane_lower: got %h expected ab12", dout0); else passed++;
        read0_end;
    endtask

    task automatic test_single_commit;
        Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 16'h0010; Data_in = 16'h0001;
        step;
        Data_in = 16'h0002;
        step;
        release_bus;
        step; step;
        read0_start(16'h0010);
        total++; if (dout0 !== 16'h0001) $display("FAIL single_commit: got %h expected 0001", dout0); else passed++;
        read0_end;
    endtask

    task automatic test_out_of_range;
        write0(16'h0000, 16'h7777, 1'b0, 1'b0);
        write0(16'h8000, 16'h5555, 1'b0, 1'b0);
        read0_start(16'h8000);
        total++; if (dout0 !== 16'h0000) $display("FAIL oor_read: got %h expected 0000", dout0); else passed++;
        total++; if (rdy0 !== 1'b1) $display("FAIL oor_ready: got %b expected 1", rdy0); else passed++;
        read0_end;
        read0_start(16'h0000);
        total++; if (dout0 !== 16'h7777) $display("FAIL oor_no_alias: got %h expected 7777", dout0); else passed++;
        read0_end;
    endtask

    task automatic test_io_word;
        Switches = 16'h3000;
        read0_start(16'hFFFF);
        total++; if (dout0 !== EXP_IO_RD) $display("FAIL io_read: got %h expected %h", dout0, EXP_IO_RD); else passed++;
        read0_end;
        write0(16'hFFFF, 16'h00C5, 1'b0, 1'b0);
        total++; if (hex0 !== EXP_HEX_1) $display("FAIL io_hex: got %h expected %h", hex0, EXP_HEX_1); else passed++;
        write0(16'hFFFF, 16'hAA11, 1'b1, 1'b0);
        total++; if (hex0 !== EXP_HEX_2) $display("FAIL io_hex_lane: got %h expected %h", hex0, EXP_HEX_2); else passed++;
        read0_start(16'h03FF);
        Switches = 16'h0000;
        read0_end;
    endtask

    task automatic test_wait_states;
        Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 16'h0020; Data_in = 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            step;
            total++; if (rdy3 !== 1'b0) $display("FAIL w3_wr_early_%0d: got %b expected 0", k, rdy3); else passed++;
        end
        step;
        total++; if (rdy3 !== 1'b1) $display("FAIL w3_wr_ready: got %b expected 1", rdy3); else passed++;
        release_bus;
        step; step;
        Mem_CE = 1'b0; Mem_OE = 1'b0; ADDR = 16'h0020;
        step; step; step;
        total++; if (rdy3 !== 1'b0) $display("FAIL w3_rd_early: got %b expected 0", rdy3); else passed++;
        step;
        total++; if (rdy3 !== 1'b1) $display("FAIL w3_rd_ready: got %b expected 1", rdy3); else passed++;
        total++; if (dout3 !== 16'hBEEF) $display("FAIL w3_rd_data: got %h expected beef", dout3); else passed++;
        release_bus;
        step; step;
    endtask

    task automatic test_abort;
        Mem_CE = 1'b0; Mem_OE = 1'b0; ADDR = 16'h0020;
        step;
        release_bus;
        for (int k = 0; k < 4; k++) begin
            step;
            total++; if (rdy3 !== 1'b0) $display("FAIL abort_ready_%0d: got %b expected 0", k, rdy3); else passed++;
        end
        Mem_CE = 1'b0; Mem_OE = 1'b0;
        step; step; step;
        total++; if (rdy3 !== 1'b0) $display("FAIL abort_retry_early: got %b expected 0", rdy3); else passed++;
        step;
        total++; if (rdy3 !== 1'b1) $display("FAIL abort_retry_ready: got %b expected 1", rdy3); else passed++;
        release_bus;
        step; step;
    endtask

    task automatic test_reset_mid_write;
        Mem_CE = 1'b0; Mem_OE = 1'b0; ADDR = 16'h0020;
        step; step; step;
        total++; if (dout2 !== 16'hBEEF) $display("FAIL w2_pre_data: got %h expected beef", dout2); else passed++;
        release_bus;
        step; step;
        Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 16'h0020; Data_in = 16'h1111;
        step; step;
        Reset = 1'b0;
        release_bus;
        step;
        total++; if (rdy2 !== 1'b0) $display("FAIL w2_reset_ready: got %b expected 0", rdy2); else passed++;
        total++; if (dout2 !== 16'h0000) $display("FAIL w2_reset_dout: got %h expected 0000", dout2); else passed++;
        Reset = 1'b1;
        step;
        Mem_CE = 1'b0; Mem_OE = 1'b0; ADDR = 16'h0020;
        step; step; step;
        total++; if (rdy2 !== 1'b1) $display("FAIL w2_after_ready: got %b expected 1", rdy2); else passed++;
        total++; if (dout2 !== 16'hBEEF) $display("FAIL w2_array_intact: got %h expected beef", dout2); else passed++;
        release_bus;
        step; step;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_byte_lanes;
        test_single_commit;
        test_out_of_range;
        test_io_word;
        test_wait_states;
        test_abort;
        test_reset_mid_write;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
